// File: rtl/cgra_config_receiver.sv
// Serial-to-parallel receiver for the CGRA configuration bitstream: shifts bits into a shadow
// register and commits the whole word on the configurator's done edge. Optional macro: CFG_RX_PARITY_EN.
module cgra_config_receiver #(
    parameter int NUM_BITS = 816
) (
    input  logic                clock_i,
    input  logic                reset_n_i,
    input  logic                bit_valid_i,
    input  logic                bitstream_i,
    input  logic                cfg_done_i,
    input  logic                clear_i,
    output logic [NUM_BITS-1:0] config_out_o,
    output logic                config_valid_o,
    output logic                busy_o,
    output logic [1:0]          error_o,
    output logic [31:0]         bit_count_o
);

`ifdef CFG_RX_PARITY_EN
    localparam int STREAM_LEN = NUM_BITS + 1;
`else
    localparam int STREAM_LEN = NUM_BITS;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT_DONE,
        S_ERROR
    } state_t;

    state_t              state_q;
    logic [NUM_BITS-1:0] shreg_q, shreg_d;
    logic [NUM_BITS-1:0] config_out_q;
    logic                config_valid_q;
    logic                busy_q;
    logic [1:0]          error_q;
    logic [31:0]         bit_count_q, count_d;
    logic                done_q;

    logic accept, done_edge, full, shift_en, finish, parity_bad;

`ifdef CFG_RX_PARITY_EN
    logic par_err_q, par_err_d;
`endif

    always_comb begin
        accept    = bit_valid_i && (state_q == S_IDLE || state_q == S_SHIFT);
        done_edge = cfg_done_i && !done_q;

        count_d = bit_count_q;
        if (accept) begin
            count_d = (state_q == S_IDLE) ? 32'd1 : bit_count_q + 32'd1;
        end
        full = (count_d == 32'(STREAM_LEN));

`ifdef CFG_RX_PARITY_EN
        // The trailing parity bit is checked on arrival but never enters the shadow register.
        shift_en  = accept && !full;
        par_err_d = par_err_q;
        if (accept && full) begin
            par_err_d = ^{shreg_q, bitstream_i};
        end
        parity_bad = par_err_d;
`else
        shift_en   = accept;
        parity_bad = 1'b0;
`endif

        shreg_d = shreg_q;
        if (shift_en) begin
            shreg_d = {shreg_q[NUM_BITS-2:0], bitstream_i};
        end

        // Uses the post-accept count, so a final bit arriving with the done edge commits at once.
        finish = done_edge && full && (state_q != S_ERROR)
                 && !(state_q == S_WAIT_DONE && bit_valid_i);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= S_IDLE;
            shreg_q        <= '0;
            config_out_q   <= '0;
            config_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            error_q        <= 2'd0;
            bit_count_q    <= 32'd0;
            done_q         <= 1'b0;
`ifdef CFG_RX_PARITY_EN
            par_err_q      <= 1'b0;
`endif
        end else begin
            done_q <= cfg_done_i;
            if (clear_i) begin
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                error_q     <= 2'd0;
                bit_count_q <= 32'd0;
            end else if (state_q != S_ERROR) begin
                shreg_q     <= shreg_d;
                bit_count_q <= count_d;
`ifdef CFG_RX_PARITY_EN
                par_err_q   <= par_err_d;
`endif
                if (state_q == S_WAIT_DONE && bit_valid_i) begin
                    state_q <= S_ERROR;
                    error_q <= 2'd2;
                    busy_q  <= 1'b0;
                end else if (finish && parity_bad) begin
                    state_q <= S_ERROR;
                    error_q <= 2'd3;
                    busy_q  <= 1'b0;
                end else if (finish) begin
                    config_out_q   <= shreg_d;
                    config_valid_q <= 1'b1;
                    bit_count_q    <= 32'd0;
                    state_q        <= S_IDLE;
                    busy_q         <= 1'b0;
                end else if (done_edge) begin
                    state_q <= S_ERROR;
                    error_q <= 2'd1;
                    busy_q  <= 1'b0;
                end else if (full) begin
                    state_q <= S_WAIT_DONE;
                    busy_q  <= 1'b1;
                end else if (accept) begin
                    state_q <= S_SHIFT;
                    busy_q  <= 1'b1;
                end
            end
        end
    end

    assign config_out_o   = config_out_q;
    assign config_valid_o = config_valid_q;
    assign busy_o         = busy_q;
    assign error_o        = error_q;
    assign bit_count_o    = bit_count_q;

endmodule

// File: tb/tb_cgra_config_receiver.sv
// Directed bench for cgra_config_receiver with NUM_BITS=8; expected values are hand-computed.
module tb_cgra_config_receiver;

    localparam int NB = 8;
`ifdef CFG_RX_PARITY_EN
    localparam int LEN = NB + 1;
`else
    localparam int LEN = NB;
`endif

    logic          clock_i = 1'b0;
    logic          reset_n_i;
    logic          bit_valid_i;
    logic          bitstream_i;
    logic          cfg_done_i;
    logic          clear_i;
    logic [NB-1:0] config_out_o;
    logic          config_valid_o;
    logic          busy_o;
    logic [1:0]    error_o;
    logic [31:0]   bit_count_o;

    int checks   = 0;
    int failures = 0;

    cgra_config_receiver #(.NUM_BITS(NB)) dut (
        .clock_i        (clock_i),
        .reset_n_i      (reset_n_i),
        .bit_valid_i    (bit_valid_i),
        .bitstream_i    (bitstream_i),
        .cfg_done_i     (cfg_done_i),
        .clear_i        (clear_i),
        .config_out_o   (config_out_o),
        .config_valid_o (config_valid_o),
        .busy_o         (busy_o),
        .error_o        (error_o),
        .bit_count_o    (bit_count_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Sends one full stream MSB first (plus even parity when enabled); optionally raises
    // cfg_done together with the final bit.
    task automatic send_word(input logic [7:0] w, input bit done_last);
        for (int k = 0; k < LEN; k++) begin
            bit_valid_i = 1'b1;
            bitstream_i = (k < NB) ? w[7-k] : ^w;
            cfg_done_i  = done_last && (k == LEN - 1);
            tick();
        end
        bit_valid_i = 1'b0;
        bitstream_i = 1'b0;
    endtask

    initial begin
        reset_n_i   = 1'b0;
        bit_valid_i = 1'b0;
        bitstream_i = 1'b0;
        cfg_done_i  = 1'b0;
        clear_i     = 1'b0;
        tick();
        tick();
        chk("rst_config_out", 64'(config_out_o), 64'h0);
        chk("rst_valid", 64'(config_valid_o), 64'h0);
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_error", 64'(error_o), 64'h0);
        chk("rst_bit_count", 64'(bit_count_o), 64'h0);
        reset_n_i = 1'b1;
        tick();

        // Underrun: 5 bits then done
        for (int k = 0; k < 5; k++) begin
            bit_valid_i = 1'b1;
            bitstream_i = 1'b1;
            tick();
            if (k == 0) chk("first_bit_count", 64'(bit_count_o), 64'd1);
        end
        bit_valid_i = 1'b0;
        chk("under_count", 64'(bit_count_o), 64'd5);
        chk("under_busy", 64'(busy_o), 64'd1);
        cfg_done_i = 1'b1;
        tick();
        chk("under_error", 64'(error_o), 64'd1);
        chk("under_valid", 64'(config_valid_o), 64'd0);
        chk("under_busy_low", 64'(busy_o), 64'd0);
        tick();
        chk("under_error_held", 64'(error_o), 64'd1);
        clear_i    = 1'b1;
        cfg_done_i = 1'b0;
        tick();
        clear_i = 1'b0;
        chk("clear_error", 64'(error_o), 64'd0);
        chk("clear_count", 64'(bit_count_o), 64'd0);

        // Normal load of 8'hB2, commit on the edge after the last bit
        send_word(8'hB2, 1'b0);
        chk("norm_count", 64'(bit_count_o), 64'(LEN));
        chk("norm_busy", 64'(busy_o), 64'd1);
        chk("norm_valid_pre", 64'(config_valid_o), 64'd0);
        cfg_done_i = 1'b1;
        tick();
        chk("norm_config_out", 64'(config_out_o), 64'hB2);
        chk("norm_valid", 64'(config_valid_o), 64'd1);
        chk("norm_error", 64'(error_o), 64'd0);
        chk("norm_busy_low", 64'(busy_o), 64'd0);
        chk("norm_count_zero", 64'(bit_count_o), 64'd0);

        // Back-to-back: old word stays visible until the second commit
        send_word(8'h5A, 1'b0);
        chk("b2b_old_word", 64'(config_out_o), 64'hB2);
        cfg_done_i = 1'b1;
        tick();
        chk("b2b_new_word", 64'(config_out_o), 64'h5A);
        chk("b2b_valid", 64'(config_valid_o), 64'd1);

        // Overrun: one bit beyond the stream with done low
        send_word(8'hFF, 1'b0);
        bit_valid_i = 1'b1;
        bitstream_i = 1'b1;
        tick();
        bit_valid_i = 1'b0;
        chk("over_error", 64'(error_o), 64'd2);
        chk("over_config_out", 64'(config_out_o), 64'h5A);
        chk("over_valid", 64'(config_valid_o), 64'd1);
        chk("over_busy", 64'(busy_o), 64'd0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("over_clear", 64'(error_o), 64'd0);

        // Asynchronous reset after 3 bits
        for (int k = 0; k < 3; k++) begin
            bit_valid_i = 1'b1;
            bitstream_i = k[0];
            tick();
        end
        bit_valid_i = 1'b0;
        #1 reset_n_i = 1'b0;
        #1;
        chk("arst_config_out", 64'(config_out_o), 64'h0);
        chk("arst_valid", 64'(config_valid_o), 64'h0);
        chk("arst_busy", 64'(busy_o), 64'h0);
        chk("arst_count", 64'(bit_count_o), 64'h0);
        tick();
        reset_n_i = 1'b1;
        send_word(8'hC3, 1'b0);
        cfg_done_i = 1'b1;
        tick();
        chk("arst_recommit", 64'(config_out_o), 64'hC3);
        chk("arst_revalid", 64'(config_valid_o), 64'd1);

        // Final bit and done edge on the same clock edge commit together
        send_word(8'h3C, 1'b1);
        chk("same_edge_word", 64'(config_out_o), 64'h3C);
        chk("same_edge_count", 64'(bit_count_o), 64'd0);
        chk("same_edge_error", 64'(error_o), 64'd0);

`ifdef CFG_RX_PARITY_EN
        // 8'hB2 has even weight, so a trailing 1 is a parity error
        cfg_done_i = 1'b0;
        for (int k = 0; k < LEN; k++) begin
            logic [7:0] w;
            w = 8'hB2;
            bit_valid_i = 1'b1;
            bitstream_i = (k < NB) ? w[7-k] : 1'b1;
            tick();
        end
        bit_valid_i = 1'b0;
        cfg_done_i  = 1'b1;
        tick();
        chk("parity_error", 64'(error_o), 64'd3);
        chk("parity_no_commit", 64'(config_out_o), 64'h3C);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
